// File: rtl/vga_sync_gen_if.sv
// VGA sync bundle: raster position, syncs, active flag
// and their pipeline-delayed copies.
interface vga_sync_gen_if;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic       o_H_Sync;
  logic       o_V_Sync;
  logic       o_Active;
  logic       o_Frame_Start;
  logic       o_H_Sync_Dly;
  logic       o_V_Sync_Dly;
  logic       o_Active_Dly;

  modport master (
    output o_Col_Count,
    output o_Row_Count,
    output o_H_Sync,
    output o_V_Sync,
    output o_Active,
    output o_Frame_Start,
    output o_H_Sync_Dly,
    output o_V_Sync_Dly,
    output o_Active_Dly
  );

  modport slave (
    input o_Col_Count,
    input o_Row_Count,
    input o_H_Sync,
    input o_V_Sync,
    input o_Active,
    input o_Frame_Start,
    input o_H_Sync_Dly,
    input o_V_Sync_Dly,
    input o_Active_Dly
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator with
// registered, mutually aligned outputs and a sync delay line.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic           CLK,
  input  logic           i_Rst_L,
  input  logic           i_Enable,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       act_q, act_d;
  logic       fs_q, fs_d;

  // Next position; outputs decode the next position so they
  // line up with the counters they are registered alongside.
  // Disabled cycles repeat the current position, so every
  // decoded output (frame start included) holds.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_Enable) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
    hs_d  = !((col_d >= HS_BEG) && (col_d < HS_END));
    vs_d  = !((row_d >= VS_BEG) && (row_d < VS_END));
    act_d = (col_d < H_VIS) && (row_d < V_VIS);
    fs_d  = (col_d == '0) && (row_d == '0);
  end

  // Position and decode registers; reset parks on the last
  // pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q <= H_LAST;
      row_q <= V_LAST;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      fs_q  <= fs_d;
    end
  end

  assign vga.o_Col_Count   = col_q;
  assign vga.o_Row_Count   = row_q;
  assign vga.o_H_Sync      = hs_q;
  assign vga.o_V_Sync      = vs_q;
  assign vga.o_Active      = act_q;
  assign vga.o_Frame_Start = fs_q;

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign vga.o_H_Sync_Dly = hs_q;
      assign vga.o_V_Sync_Dly = vs_q;
      assign vga.o_Active_Dly = act_q;
    end else begin : g_dly
      logic [2:0] dly_q [SYNC_DELAY];
      logic [2:0] dly_d [SYNC_DELAY];

      // Shift {hsync, vsync, active} one stage per enabled edge.
      always_comb begin
        dly_d = dly_q;
        if (i_Enable) begin
          dly_d[0] = {hs_q, vs_q, act_q};
          for (int i = 1; i < SYNC_DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
          end
        end
      end

      // Delay stages reset to the idle decode {1,1,0}.
      always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          for (int i = 0; i < SYNC_DELAY; i++) begin
            dly_q[i] <= 3'b110;
          end
        end else begin
          dly_q <= dly_d;
        end
      end

      assign vga.o_H_Sync_Dly = dly_q[SYNC_DELAY-1][2];
      assign vga.o_V_Sync_Dly = dly_q[SYNC_DELAY-1][1];
      assign vga.o_Active_Dly = dly_q[SYNC_DELAY-1][0];
    end
  endgenerate

endmodule
